// File: rtl/exe_mem_skid_reg.sv
// ---------------------------------------------------------------------------
// exe_mem_skid_reg
//
// Purpose:
//   EX->MEM pipeline register with a valid/ready handshake on both sides, a
//   two-entry skid buffer (OUT + SKID) and a flush input. While the memory
//   stage stalls, back-to-back execute results are held in order without
//   being dropped or duplicated. Empty or flushed slots are presented to MEM
//   as clean bubbles with all write enables low. Cycles in which MEM holds
//   off a valid entry are counted in a saturating stall counter.
//
// Parameters:
//   ADDR_WIDTH   memory address width
//   DATA_WIDTH   memory store-data width
//   RADDR_WIDTH  register-file write-address width
//   RDATA_WIDTH  register-file write-data width
//   CNT_WIDTH    stall-counter width
//   MEM_OP_NONE  mem_op code meaning "no memory access"
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   valid_i      execute stage presents a valid instruction
//   ready_o      this block can accept an instruction this cycle
//   flush_i      discard the held entries and the incoming one
//   reg_waddr_i / reg_we_i / reg_wdata_i   register writeback payload from EX
//   mem_we_i / mem_addr_i / mem_data_i / mem_op_i   memory payload from EX
//   valid_o      head entry towards MEM is valid
//   ready_i      MEM takes the head entry this cycle
//   reg_waddr_o / reg_we_o / reg_wdata_o   head-entry register payload
//   mem_we_o / mem_addr_o / mem_data_o / mem_op_o   head-entry memory payload
//   stall_cnt_o  saturating count of cycles with valid_o=1 and ready_i=0
// ---------------------------------------------------------------------------
module exe_mem_skid_reg #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         RADDR_WIDTH = 5,
  parameter int         RDATA_WIDTH = 32,
  parameter int         CNT_WIDTH   = 16,
  parameter logic [3:0] MEM_OP_NONE = 4'd8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,

  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0]  mem_data_o,
  output logic [3:0]             mem_op_o,

  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  // The whole EX payload travels as one packed word so OUT and SKID are
  // moved and reset as a unit.
  localparam int PAYLOAD_W = RADDR_WIDTH + 1 + RDATA_WIDTH + 1 +
                             ADDR_WIDTH + DATA_WIDTH + 4;

  // Reset image: every field zero except mem_op, which must read "none".
  localparam logic [PAYLOAD_W-1:0] PAYLOAD_RST = {{(PAYLOAD_W-4){1'b0}}, MEM_OP_NONE};

  logic [PAYLOAD_W-1:0] w_in_payload;
  logic [PAYLOAD_W-1:0] r_out_payload;
  logic [PAYLOAD_W-1:0] r_skid_payload;
  logic                 r_out_valid;
  logic                 r_skid_valid;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic                 w_accept;
  logic                 w_retire;
  logic                 w_stall;

  logic [RADDR_WIDTH-1:0] w_out_reg_waddr;
  logic                   w_out_reg_we;
  logic [RDATA_WIDTH-1:0] w_out_reg_wdata;
  logic                   w_out_mem_we;
  logic [ADDR_WIDTH-1:0]  w_out_mem_addr;
  logic [DATA_WIDTH-1:0]  w_out_mem_data;
  logic [3:0]             w_out_mem_op;

  assign w_in_payload = {reg_waddr_i, reg_we_i, reg_wdata_i,
                         mem_we_i, mem_addr_i, mem_data_i, mem_op_i};

  assign {w_out_reg_waddr, w_out_reg_we, w_out_reg_wdata,
          w_out_mem_we, w_out_mem_addr, w_out_mem_data, w_out_mem_op} = r_out_payload;

  // ready_o comes straight from the SKID valid flop, so the upstream
  // handshake never depends combinationally on ready_i.
  assign ready_o  = ~r_skid_valid;
  assign valid_o  = r_out_valid;
  assign w_accept = valid_i & ~r_skid_valid;
  assign w_retire = r_out_valid & ready_i;
  assign w_stall  = r_out_valid & ~ready_i;

  // Storage update. Flush drops everything, including the entry offered in
  // the same cycle; payload registers simply keep their stale contents since
  // they are masked whenever the matching valid bit is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid    <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_out_payload  <= PAYLOAD_RST;
      r_skid_payload <= PAYLOAD_RST;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_retire) begin
      if (r_skid_valid) begin
        // Older SKID entry advances; a same-cycle accept queues behind it.
        r_out_payload <= r_skid_payload;
        r_out_valid   <= 1'b1;
        r_skid_valid  <= w_accept;
        if (w_accept) begin
          r_skid_payload <= w_in_payload;
        end
      end else if (w_accept) begin
        r_out_payload <= w_in_payload;
        r_out_valid   <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid) begin
        r_out_payload <= w_in_payload;
        r_out_valid   <= 1'b1;
      end else begin
        r_skid_payload <= w_in_payload;
        r_skid_valid   <= 1'b1;
      end
    end
  end

  // Stall counter: saturates at all-ones and deliberately ignores flush so
  // the figure reflects total MEM back-pressure since reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Bubble masking: side-effecting fields are forced inactive when no valid
  // entry is presented; the data fields hold their last value.
  assign reg_waddr_o = w_out_reg_waddr;
  assign reg_wdata_o = w_out_reg_wdata;
  assign mem_addr_o  = w_out_mem_addr;
  assign mem_data_o  = w_out_mem_data;
  assign reg_we_o    = r_out_valid & w_out_reg_we;
  assign mem_we_o    = r_out_valid & w_out_mem_we;
  assign mem_op_o    = r_out_valid ? w_out_mem_op : MEM_OP_NONE;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_skid_reg
//
// Purpose:
//   Self-checking bench for exe_mem_skid_reg. A fixed vector table covers
//   streaming, stall fill, flush, reset mid-stall and store bubbles; a short
//   hand sequence saturates a 4-bit stall counter; a random phase is checked
//   against a queue-based reference model.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_exe_mem_skid_reg;

  typedef struct {
    logic [4:0]  waddr;
    logic        regWe;
    logic [31:0] wdata;
    logic        memWe;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  op;
  } entryT;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        vin;
    logic        rdy;
    logic [31:0] data;
    logic        mw;
    logic [3:0]  op;
    logic        expValid;
    logic        expReady;
    logic        expMemWe;
    logic [31:0] expData;
    logic [3:0]  expOp;
    logic        expZero;
  } vecT;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        validIn;
  logic        readyIn;
  logic [4:0]  regWaddrIn;
  logic        regWeIn;
  logic [31:0] regWdataIn;
  logic        memWeIn;
  logic [31:0] memAddrIn;
  logic [31:0] memDataIn;
  logic [3:0]  memOpIn;

  logic        readyOut, validOut, regWeOut, memWeOut;
  logic [4:0]  regWaddrOut;
  logic [31:0] regWdataOut, memAddrOut, memDataOut;
  logic [3:0]  memOpOut;
  logic [15:0] stallCnt;

  logic        readyOut4, validOut4, regWeOut4, memWeOut4;
  logic [4:0]  regWaddrOut4;
  logic [31:0] regWdataOut4, memAddrOut4, memDataOut4;
  logic [3:0]  memOpOut4;
  logic [3:0]  stallCnt4;

  int compared = 0;
  int mismatched = 0;

  entryT modelQ[$];
  entryT curEntry;
  int    cnt16 = 0;
  int    cnt4 = 0;

  always #5 clk = ~clk;

  exe_mem_skid_reg dut (
    .clk_i(clk), .rst_i(rst), .valid_i(validIn), .ready_o(readyOut), .flush_i(flush),
    .reg_waddr_i(regWaddrIn), .reg_we_i(regWeIn), .reg_wdata_i(regWdataIn),
    .mem_we_i(memWeIn), .mem_addr_i(memAddrIn), .mem_data_i(memDataIn), .mem_op_i(memOpIn),
    .valid_o(validOut), .ready_i(readyIn),
    .reg_waddr_o(regWaddrOut), .reg_we_o(regWeOut), .reg_wdata_o(regWdataOut),
    .mem_we_o(memWeOut), .mem_addr_o(memAddrOut), .mem_data_o(memDataOut), .mem_op_o(memOpOut),
    .stall_cnt_o(stallCnt)
  );

  exe_mem_skid_reg #(.CNT_WIDTH(4)) dutCnt4 (
    .clk_i(clk), .rst_i(rst), .valid_i(validIn), .ready_o(readyOut4), .flush_i(flush),
    .reg_waddr_i(regWaddrIn), .reg_we_i(regWeIn), .reg_wdata_i(regWdataIn),
    .mem_we_i(memWeIn), .mem_addr_i(memAddrIn), .mem_data_i(memDataIn), .mem_op_i(memOpIn),
    .valid_o(validOut4), .ready_i(readyIn),
    .reg_waddr_o(regWaddrOut4), .reg_we_o(regWeOut4), .reg_wdata_o(regWdataOut4),
    .mem_we_o(memWeOut4), .mem_addr_o(memAddrOut4), .mem_data_o(memDataOut4), .mem_op_o(memOpOut4),
    .stall_cnt_o(stallCnt4)
  );

  // Builds a vector record; keeps the table below one line per cycle.
  function automatic vecT mk(input logic r, f, v, rd, input logic [31:0] d,
                             input logic mw, input logic [3:0] op,
                             input logic eV, eR, eMw, input logic [31:0] eD,
                             input logic [3:0] eOp, input logic eZ);
    vecT t;
    t.rst = r; t.flush = f; t.vin = v; t.rdy = rd; t.data = d; t.mw = mw; t.op = op;
    t.expValid = eV; t.expReady = eR; t.expMemWe = eMw; t.expData = eD;
    t.expOp = eOp; t.expZero = eZ;
    return t;
  endfunction

  // Table payloads are derived from one data word so each entry is distinct.
  function automatic entryT entryFromData(input logic [31:0] d, input logic mw,
                                          input logic [3:0] op);
    entryT e;
    e.waddr = d[4:0];
    e.regWe = 1'b1;
    e.wdata = d;
    e.memWe = mw;
    e.addr  = d + 32'h1000;
    e.data  = ~d;
    e.op    = op;
    return e;
  endfunction

  task automatic applyStimulus(input logic r, f, v, rd, input entryT e);
    rst        = r;
    flush      = f;
    validIn    = v;
    readyIn    = rd;
    curEntry   = e;
    regWaddrIn = e.waddr;
    regWeIn    = e.regWe;
    regWdataIn = e.wdata;
    memWeIn    = e.memWe;
    memAddrIn  = e.addr;
    memDataIn  = e.data;
    memOpIn    = e.op;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries. Counter sees the state
  // before the edge; flush empties it; otherwise retire pops, accept pushes.
  task automatic modelStep();
    bit canAccept;
    if (rst) begin
      modelQ.delete();
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      if (modelQ.size() > 0 && !readyIn) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (flush) begin
        modelQ.delete();
      end else begin
        canAccept = modelQ.size() < 2;
        if (modelQ.size() > 0 && readyIn) void'(modelQ.pop_front());
        if (validIn && canAccept) modelQ.push_back(curEntry);
      end
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkModel();
    bit v;
    v = modelQ.size() > 0;
    checkOutput("valid_o", 32'(validOut), 32'(v));
    checkOutput("ready_o", 32'(readyOut), 32'(modelQ.size() < 2));
    checkOutput("stall_cnt16", 32'(stallCnt), 32'(cnt16));
    checkOutput("stall_cnt4", 32'(stallCnt4), 32'(cnt4));
    if (v) begin
      checkOutput("reg_waddr_o", 32'(regWaddrOut), 32'(modelQ[0].waddr));
      checkOutput("reg_we_o", 32'(regWeOut), 32'(modelQ[0].regWe));
      checkOutput("reg_wdata_o", regWdataOut, modelQ[0].wdata);
      checkOutput("mem_we_o", 32'(memWeOut), 32'(modelQ[0].memWe));
      checkOutput("mem_addr_o", memAddrOut, modelQ[0].addr);
      checkOutput("mem_data_o", memDataOut, modelQ[0].data);
      checkOutput("mem_op_o", 32'(memOpOut), 32'(modelQ[0].op));
    end else begin
      checkOutput("bubble reg_we_o", 32'(regWeOut), 32'd0);
      checkOutput("bubble mem_we_o", 32'(memWeOut), 32'd0);
      checkOutput("bubble mem_op_o", 32'(memOpOut), 32'd8);
    end
  endtask

  initial begin
    vecT   vecs[$];
    entryT e;

    // rst flush vin rdy data mw op | expValid expReady expMemWe expData expOp expZero
    vecs.push_back(mk(1,0,0,0, 32'h0,  0,2, 0,1,0, 32'h0,  8, 1)); // reset
    vecs.push_back(mk(0,0,1,1, 32'h1,  0,2, 1,1,0, 32'h1,  2, 0)); // streaming 1..4
    vecs.push_back(mk(0,0,1,1, 32'h2,  0,2, 1,1,0, 32'h2,  2, 0));
    vecs.push_back(mk(0,0,1,1, 32'h3,  0,2, 1,1,0, 32'h3,  2, 0));
    vecs.push_back(mk(0,0,1,1, 32'h4,  0,2, 1,1,0, 32'h4,  2, 0));
    vecs.push_back(mk(0,0,0,1, 32'h0,  0,2, 0,1,0, 32'h0,  8, 0));
    vecs.push_back(mk(0,0,1,0, 32'hA,  0,2, 1,1,0, 32'hA,  2, 0)); // stall fill A,B
    vecs.push_back(mk(0,0,1,0, 32'hB,  0,2, 1,0,0, 32'hA,  2, 0));
    vecs.push_back(mk(0,0,1,0, 32'hC,  0,2, 1,0,0, 32'hA,  2, 0)); // C held off
    vecs.push_back(mk(0,0,1,1, 32'hC,  0,2, 1,1,0, 32'hB,  2, 0));
    vecs.push_back(mk(0,0,1,1, 32'hC,  0,2, 1,1,0, 32'hC,  2, 0));
    vecs.push_back(mk(0,0,0,1, 32'h0,  0,2, 0,1,0, 32'h0,  8, 0));
    vecs.push_back(mk(0,0,1,0, 32'hD,  0,2, 1,1,0, 32'hD,  2, 0)); // flush when full
    vecs.push_back(mk(0,0,1,0, 32'hE,  0,2, 1,0,0, 32'hD,  2, 0));
    vecs.push_back(mk(0,1,1,0, 32'hF,  0,2, 0,1,0, 32'h0,  8, 0));
    vecs.push_back(mk(0,0,0,1, 32'h0,  0,2, 0,1,0, 32'h0,  8, 0));
    vecs.push_back(mk(0,0,1,0, 32'h10, 0,2, 1,1,0, 32'h10, 2, 0)); // reset mid-stall
    vecs.push_back(mk(0,0,1,0, 32'h11, 0,2, 1,0,0, 32'h10, 2, 0));
    vecs.push_back(mk(1,0,0,0, 32'h0,  0,2, 0,1,0, 32'h0,  8, 1));
    vecs.push_back(mk(0,0,0,0, 32'h0,  0,2, 0,1,0, 32'h0,  8, 0));
    vecs.push_back(mk(0,0,1,0, 32'h5,  1,7, 1,1,1, 32'h5,  7, 0)); // store then bubble
    vecs.push_back(mk(0,0,0,1, 32'h0,  0,2, 0,1,0, 32'h0,  8, 0));

    $display("[TB] vector table: %0d rows", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].rdy,
                    entryFromData(vecs[i].data, vecs[i].mw, vecs[i].op));
      runCycle();
      checkOutput($sformatf("vec%0d valid_o", i), 32'(validOut), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d ready_o", i), 32'(readyOut), 32'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d reg_we_o", i), 32'(regWeOut), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d mem_we_o", i), 32'(memWeOut), 32'(vecs[i].expMemWe));
      checkOutput($sformatf("vec%0d mem_op_o", i), 32'(memOpOut), 32'(vecs[i].expOp));
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d reg_wdata_o", i), regWdataOut, vecs[i].expData);
      if (vecs[i].expZero) begin
        checkOutput($sformatf("vec%0d rst reg_waddr_o", i), 32'(regWaddrOut), 32'd0);
        checkOutput($sformatf("vec%0d rst reg_wdata_o", i), regWdataOut, 32'd0);
        checkOutput($sformatf("vec%0d rst mem_addr_o", i), memAddrOut, 32'd0);
        checkOutput($sformatf("vec%0d rst mem_data_o", i), memDataOut, 32'd0);
        checkOutput($sformatf("vec%0d rst stall_cnt_o", i), 32'(stallCnt), 32'd0);
      end
    end

    // Counter saturation: one entry held for 20 stalled cycles.
    $display("[TB] stall counter saturation");
    e = entryFromData(32'h77, 1'b0, 4'd2);
    applyStimulus(1, 0, 0, 0, e);
    runCycle();
    applyStimulus(0, 0, 1, 0, e);
    runCycle();
    applyStimulus(0, 0, 0, 0, e);
    for (int c = 0; c < 20; c++) runCycle();
    checkOutput("sat stall_cnt16", 32'(stallCnt), 32'd20);
    checkOutput("sat stall_cnt4", 32'(stallCnt4), 32'd15);
    runCycle();
    checkOutput("sat stall_cnt4 hold", 32'(stallCnt4), 32'd15);
    // Flush must not clear the counter.
    applyStimulus(0, 1, 0, 0, e);
    runCycle();
    checkOutput("flush keeps stall_cnt16", 32'(stallCnt), 32'd22);

    // Random traffic against the reference model.
    $display("[TB] random traffic");
    applyStimulus(1, 0, 0, 0, e);
    runCycle();
    checkModel();
    for (int c = 0; c < 600; c++) begin
      e.waddr = 5'($urandom);
      e.regWe = 1'($urandom);
      e.wdata = $urandom;
      e.memWe = 1'($urandom);
      e.addr  = $urandom;
      e.data  = $urandom;
      e.op    = 4'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                    $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55, e);
      runCycle();
      checkModel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
